led_pwm_driver: RTL and testbench

Downstream consumer of the 32-bit LED PIO output port. It takes the PIO's registered control word and drives the physical LED pins with per-LED 4-bit brightness using pulse-width modulation. The control word is double-buffered, so a new setting is loaded only at a PWM period boundary and the LED outputs never glitch mid-period. It sits between the PIO's `out_port` and the top-level LED pins, in the PIO's clock domain.

---
 rtl/led_pwm_driver.sv | 106 ++++++++++
 tb/tb_led_pwm_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// Per-LED 4-bit PWM driver with a period-boundary shadow register for the PIO control word.
// Build option LED_PWM_GAMMA_EN: 255-step period with a perceptual duty-threshold table.
module led_pwm_driver #(
    parameter int NUM_LEDS = 8,
    parameter int PRESCALE = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ctrl_in,
    output logic [NUM_LEDS-1:0] led,
    output logic                period_tick
);

`ifdef LED_PWM_GAMMA_EN
    localparam int STEP_W = 8;
    localparam int STEPS  = 255;
`else
    localparam int STEP_W = 4;
    localparam int STEPS  = 15;
`endif

    // A one-cycle prescaler still needs a 1-bit register to keep the code uniform.
    localparam int PRESC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SHADOW_W = 4 * NUM_LEDS;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEPS - 1);

    // Maps a duty code to the step count below which the LED is lit.
    function automatic logic [STEP_W-1:0] thr(input logic [3:0] d);
`ifdef LED_PWM_GAMMA_EN
        logic [STEP_W-1:0] t;
        case (d)
            4'd0:    t = 8'd0;
            4'd1:    t = 8'd1;
            4'd2:    t = 8'd2;
            4'd3:    t = 8'd4;
            4'd4:    t = 8'd6;
            4'd5:    t = 8'd9;
            4'd6:    t = 8'd13;
            4'd7:    t = 8'd18;
            4'd8:    t = 8'd25;
            4'd9:    t = 8'd34;
            4'd10:   t = 8'd47;
            4'd11:   t = 8'd64;
            4'd12:   t = 8'd88;
            4'd13:   t = 8'd120;
            4'd14:   t = 8'd175;
            default: t = 8'd255;
        endcase
        return t;
`else
        return d;
`endif
    endfunction

    logic [PRESC_W-1:0]  presc_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [SHADOW_W-1:0] shadow_reg;
    logic [NUM_LEDS-1:0] led_next;
    logic                step_en;
    logic                pend;
    logic                ctrl_unused;

    // Bits above the configured LED count are deliberately ignored.
    assign ctrl_unused = ^ctrl_in;

    assign step_en = (presc_reg == PRESC_LAST);
    assign pend    = step_en && (step_reg == STEP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg   <= '0;
            step_reg    <= '0;
            shadow_reg  <= '0;
            period_tick <= 1'b0;
        end else begin
            presc_reg <= step_en ? '0 : presc_reg + 1'b1;
            if (step_en) begin
                step_reg <= (step_reg == STEP_LAST) ? '0 : step_reg + 1'b1;
            end
            // The control word is only sampled here so a period never mixes two settings.
            if (pend) begin
                shadow_reg <= ctrl_in[SHADOW_W-1:0];
            end
            period_tick <= pend;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic [STEP_W-1:0] thr_val;
            assign thr_val      = thr(shadow_reg[4*gi +: 4]);
            assign led_next[gi] = (step_reg < thr_val);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench for led_pwm_driver: PRESCALE=4 main instance plus a PRESCALE=1 corner instance.
module tb_led_pwm_driver;

`ifdef LED_PWM_GAMMA_EN
    localparam int STEPS = 255;
`else
    localparam int STEPS = 15;
`endif
    localparam int P      = 4;
    localparam int PERIOD = P * STEPS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset1_n = 1'b0;
    logic [31:0] ctrl_in = 32'h0;
    logic [31:0] ctrl1_in = 32'h0;
    logic [7:0]  led;
    logic [7:0]  led1;
    logic        period_tick;
    logic        tick1;

    always #5 clk = ~clk;

    led_pwm_driver #(.NUM_LEDS(8), .PRESCALE(P)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ctrl_in     (ctrl_in),
        .led         (led),
        .period_tick (period_tick)
    );

    led_pwm_driver #(.NUM_LEDS(8), .PRESCALE(1)) dut1 (
        .clk         (clk),
        .reset_n     (reset1_n),
        .ctrl_in     (ctrl1_in),
        .led         (led1),
        .period_tick (tick1)
    );

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    function automatic int thr(input int d);
`ifdef LED_PWM_GAMMA_EN
        case (d)
            0: return 0;    1: return 1;    2: return 2;    3: return 4;
            4: return 6;    5: return 9;    6: return 13;   7: return 18;
            8: return 25;   9: return 34;   10: return 47;  11: return 64;
            12: return 88;  13: return 120; 14: return 175; default: return 255;
        endcase
`else
        return d;
`endif
    endfunction

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Waits for a period tick on the selected instance; an expired bound is a failed check.
    task automatic wait_tick(input bit sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            sample();
            if ((sel ? tick1 : period_tick) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL tick_timeout: got no tick within %0d clk, expected one", bound);
        end
    endtask

    task automatic test_reset();
        logic [31:0] e, o;
        reset_n  = 1'b0;
        reset1_n = 1'b0;
        ctrl_in  = 32'hFFFF_FFFF;
        ctrl1_in = 32'h0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        repeat (3) sample();
        e = exp_q.pop_front(); o = 32'(led); checks++;
        if (o !== e) $display("FAIL reset_led_held: got %0h expected %0h", o, e); else passed++;
        e = exp_q.pop_front(); o = 32'(period_tick); checks++;
        if (o !== e) $display("FAIL reset_tick_held: got %0h expected %0h", o, e); else passed++;
        @(negedge clk);
        reset_n  = 1'b1;
        reset1_n = 1'b1;
        for (int k = 0; k < PERIOD + 4; k++) begin
            exp_q.push_back((k == PERIOD - 1) ? 32'h1 : 32'h0);
            exp_q.push_back((k >= PERIOD) ? 32'hFF : 32'h0);
        end
        for (int k = 0; k < PERIOD + 4; k++) begin
            sample();
            e = exp_q.pop_front(); o = 32'(period_tick); checks++;
            if (o !== e) $display("FAIL reset_tick cycle %0d: got %0h expected %0h", k, o, e); else passed++;
            e = exp_q.pop_front(); o = 32'(led); checks++;
            if (o !== e) $display("FAIL reset_led cycle %0d: got %0h expected %0h", k, o, e); else passed++;
        end
        $display("reset: %0d post-release cycles checked", PERIOD + 4);
    endtask

    task automatic test_duty(input logic [31:0] pattern);
        logic [31:0] e, o;
        int cnt[8];
        int ticks;
        bit ok;
        sample();
        ctrl_in = pattern;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(thr(int'((pattern >> (4 * i)) & 32'hF)) * P));
        exp_q.push_back(32'h1);
        wait_tick(1'b0, PERIOD + 2, ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            ticks = 0;
            for (int n = 1; n <= PERIOD; n++) begin
                sample();
                for (int i = 0; i < 8; i++) cnt[i] += int'(led[i] === 1'b1);
                ticks += int'(period_tick === 1'b1);
            end
            for (int i = 0; i < 8; i++) begin
                e = exp_q.pop_front(); o = 32'(cnt[i]); checks++;
                if (o !== e) $display("FAIL duty %h led%0d on-clk: got %0d expected %0d", pattern, i, o, e);
                else passed++;
            end
            e = exp_q.pop_front(); o = 32'(ticks); checks++;
            if (o !== e) $display("FAIL duty_ticks_per_period: got %0d expected %0d", o, e); else passed++;
        end else begin
            exp_q.delete();
        end
        $display("duty %h: period measured", pattern);
    endtask

    task automatic test_boundary();
        logic [31:0] e, o;
        int highs;
        bit ok;
        sample();
        ctrl_in = 32'h0;
        wait_tick(1'b0, PERIOD + 2, ok);
        if (ok) begin
            repeat (5 * P) sample();
            ctrl_in = 32'h0000_000F;
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            highs = 0;
            for (int n = 5 * P + 1; n <= PERIOD; n++) begin
                sample();
                highs += int'(led[0] !== 1'b0);
            end
            e = exp_q.pop_front(); o = 32'(highs); checks++;
            if (o !== e) $display("FAIL boundary_led0_deferred: got %0d high clk expected %0d", o, e); else passed++;
            e = exp_q.pop_front(); o = 32'(period_tick); checks++;
            if (o !== e) $display("FAIL boundary_tick: got %0h expected %0h", o, e); else passed++;
            sample();
            e = exp_q.pop_front(); o = 32'(led[0]); checks++;
            if (o !== e) $display("FAIL boundary_led0_after_pend: got %0h expected %0h", o, e); else passed++;
        end
        $display("boundary: mid-period change deferred to period end");
    endtask

    task automatic test_mid_reset();
        logic [31:0] e, o;
        int highs;
        bit ok;
        sample();
        ctrl_in = 32'h0000_0007;
        wait_tick(1'b0, PERIOD + 2, ok);
        if (ok) begin
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            repeat (2) sample();
            e = exp_q.pop_front(); o = 32'(led[0]); checks++;
            if (o !== e) $display("FAIL midreset_led0_before: got %0h expected %0h", o, e); else passed++;
            #2;
            reset_n = 1'b0;
            #1;
            e = exp_q.pop_front(); o = 32'(led); checks++;
            if (o !== e) $display("FAIL midreset_led_async: got %0h expected %0h", o, e); else passed++;
            repeat (2) sample();
            @(negedge clk);
            reset_n = 1'b1;
            highs = 0;
            for (int k = 0; k < PERIOD - 1; k++) begin
                sample();
                highs += int'(led !== 8'h00);
            end
            sample();
            highs += int'(led !== 8'h00);
            e = exp_q.pop_front(); o = 32'(highs); checks++;
            if (o !== e) $display("FAIL midreset_led_off_after_release: got %0d nonzero clk expected %0d", o, e); else passed++;
            e = exp_q.pop_front(); o = 32'(led); checks++;
            if (o !== e) $display("FAIL midreset_led_last_cycle: got %0h expected %0h", o, e); else passed++;
            e = exp_q.pop_front(); o = 32'(period_tick); checks++;
            if (o !== e) $display("FAIL midreset_first_tick: got %0h expected %0h", o, e); else passed++;
            sample();
            e = exp_q.pop_front(); o = 32'(led[0]); checks++;
            if (o !== e) $display("FAIL midreset_led0_reload: got %0h expected %0h", o, e); else passed++;
        end
        $display("mid-period reset: shadow cleared and reloaded");
    endtask

    task automatic test_prescale1();
        logic [31:0] e, o;
        int highs, ticks;
        bit ok;
        ctrl1_in = 32'h0;
        wait_tick(1'b1, STEPS + 2, ok);
        if (ok) begin
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h0);
            repeat (STEPS - 1) sample();
            // Present the new code only on the pend cycle itself.
            ctrl1_in = 32'h0000_0001;
            sample();
            ctrl1_in = 32'h0;
            e = exp_q.pop_front(); o = 32'(tick1); checks++;
            if (o !== e) $display("FAIL p1_tick_period: got %0h expected %0h", o, e); else passed++;
            highs = 0;
            ticks = 0;
            for (int n = 1; n <= STEPS; n++) begin
                sample();
                if (n == 1) begin
                    e = exp_q.pop_front(); o = 32'(led1[0]); checks++;
                    if (o !== e) $display("FAIL p1_led0_min_latency: got %0h expected %0h", o, e); else passed++;
                end
                highs += int'(led1[0] === 1'b1);
                ticks += int'(tick1 === 1'b1);
            end
            e = exp_q.pop_front(); o = 32'(highs); checks++;
            if (o !== e) $display("FAIL p1_led0_pulse_width: got %0d expected %0d", o, e); else passed++;
            e = exp_q.pop_front(); o = 32'(ticks); checks++;
            if (o !== e) $display("FAIL p1_ticks_per_period: got %0d expected %0d", o, e); else passed++;
            repeat (2) sample();
            e = exp_q.pop_front(); o = 32'(led1[0]); checks++;
            if (o !== e) $display("FAIL p1_led0_next_period: got %0h expected %0h", o, e); else passed++;
        end
        $display("prescale=1: period %0d clk, d=1 pulse checked", STEPS);
    endtask

    initial begin
        test_reset();
        test_duty(32'hF841_0000);
        test_duty(32'h0000_A7F2);
        test_boundary();
        test_mid_reset();
        test_prescale1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
